// File: rtl/execute_operand_stage_pkg.sv
// Shared CPU definitions: datapath defaults, ALU opcodes and stage control bundle.
package execute_operand_stage_pkg;

  localparam int unsigned CpuWidth  = 32;
  localparam int unsigned CpuRaddrW = 5;

  typedef enum logic [2:0] {
    AluAdd  = 3'b000,
    AluSub  = 3'b001,
    AluAnd  = 3'b010,
    AluOr   = 3'b011,
    AluXor  = 3'b100,
    AluSlt  = 3'b101,
    AluSltu = 3'b110
  } alu_op_e;

  // Control bits that must be squashed on flush or when the slot carries no instruction.
  typedef struct packed {
    logic valid;
    logic regWrite;
    logic memRead;
    logic memWrite;
  } stage_ctrl_t;

endpackage

// File: rtl/execute_operand_stage_forward_select.sv
// Bypass selector for one source operand: EX/MEM beats MEM/WB, x0 is never bypassed.
module forward_select #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] srcAddr,
  input  logic [WIDTH-1:0]   regData,
  input  logic               exMemRegWrite,
  input  logic [RADDR_W-1:0] exMemRd,
  input  logic [WIDTH-1:0]   exMemResult,
  input  logic               memWbRegWrite,
  input  logic [RADDR_W-1:0] memWbRd,
  input  logic [WIDTH-1:0]   memWbResult,
  output logic [WIDTH-1:0]   fwdData
);

  logic exMemHit;
  logic memWbHit;

  // Pick the youngest in-flight producer of srcAddr, else the registered file value.
  always_comb begin
    exMemHit = exMemRegWrite && (exMemRd != '0) && (exMemRd == srcAddr);
    memWbHit = memWbRegWrite && (memWbRd != '0) && (memWbRd == srcAddr);
    fwdData  = regData;
    if (exMemHit) begin
      fwdData = exMemResult;
    end else if (memWbHit) begin
      fwdData = memWbResult;
    end
  end

endmodule

// File: rtl/execute_operand_stage.sv
// Decode->execute pipeline register with operand forwarding and load-use detection.
module execute_operand_stage
  import execute_operand_stage_pkg::*;
#(
  parameter int unsigned WIDTH   = CpuWidth,
  parameter int unsigned RADDR_W = CpuRaddrW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               inValid,
  input  logic [WIDTH-1:0]   rs1Data,
  input  logic [WIDTH-1:0]   rs2Data,
  input  logic [WIDTH-1:0]   immediate,
  input  logic [RADDR_W-1:0] rs1Addr,
  input  logic [RADDR_W-1:0] rs2Addr,
  input  logic [RADDR_W-1:0] rdAddr,
  input  logic [2:0]         aluControlIn,
  input  logic               aluSrcImm,
  input  logic               regWriteIn,
  input  logic               memReadIn,
  input  logic               memWriteIn,
  input  logic               exMemRegWrite,
  input  logic [RADDR_W-1:0] exMemRd,
  input  logic [WIDTH-1:0]   exMemResult,
  input  logic               memWbRegWrite,
  input  logic [RADDR_W-1:0] memWbRd,
  input  logic [WIDTH-1:0]   memWbResult,
  output logic [WIDTH-1:0]   operandA,
  output logic [WIDTH-1:0]   operandB,
  output logic [2:0]         controlSignal,
  output logic [WIDTH-1:0]   storeData,
  output logic [RADDR_W-1:0] rdAddrOut,
  output logic               regWriteOut,
  output logic               memReadOut,
  output logic               memWriteOut,
  output logic               outValid,
  output logic               loadUseHazard
);

  stage_ctrl_t        ctrl_q;
  alu_op_e            aluOp_q;
  logic               aluSrcImm_q;
  logic [WIDTH-1:0]   rs1Data_q;
  logic [WIDTH-1:0]   rs2Data_q;
  logic [WIDTH-1:0]   imm_q;
  logic [RADDR_W-1:0] rs1Addr_q;
  logic [RADDR_W-1:0] rs2Addr_q;
  logic [RADDR_W-1:0] rd_q;

  logic [WIDTH-1:0]   rs1Fwd;
  logic [WIDTH-1:0]   rs2Fwd;

  // Stage register: flush squashes controls only, stall holds everything, else capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q      <= '0;
      aluOp_q     <= AluAdd;
      aluSrcImm_q <= 1'b0;
      rs1Data_q   <= '0;
      rs2Data_q   <= '0;
      imm_q       <= '0;
      rs1Addr_q   <= '0;
      rs2Addr_q   <= '0;
      rd_q        <= '0;
    end else if (flush) begin
      ctrl_q <= '0;
    end else if (!stall) begin
      ctrl_q.valid    <= inValid;
      ctrl_q.regWrite <= inValid & regWriteIn;
      ctrl_q.memRead  <= inValid & memReadIn;
      ctrl_q.memWrite <= inValid & memWriteIn;
      aluOp_q         <= alu_op_e'(aluControlIn);
      aluSrcImm_q     <= aluSrcImm;
      rs1Data_q       <= rs1Data;
      rs2Data_q       <= rs2Data;
      imm_q           <= immediate;
      rs1Addr_q       <= rs1Addr;
      rs2Addr_q       <= rs2Addr;
      rd_q            <= rdAddr;
    end
  end

  forward_select #(
    .WIDTH   (WIDTH),
    .RADDR_W (RADDR_W)
  ) u_fwd_rs1 (
    .srcAddr       (rs1Addr_q),
    .regData       (rs1Data_q),
    .exMemRegWrite (exMemRegWrite),
    .exMemRd       (exMemRd),
    .exMemResult   (exMemResult),
    .memWbRegWrite (memWbRegWrite),
    .memWbRd       (memWbRd),
    .memWbResult   (memWbResult),
    .fwdData       (rs1Fwd)
  );

  forward_select #(
    .WIDTH   (WIDTH),
    .RADDR_W (RADDR_W)
  ) u_fwd_rs2 (
    .srcAddr       (rs2Addr_q),
    .regData       (rs2Data_q),
    .exMemRegWrite (exMemRegWrite),
    .exMemRd       (exMemRd),
    .exMemResult   (exMemResult),
    .memWbRegWrite (memWbRegWrite),
    .memWbRd       (memWbRd),
    .memWbResult   (memWbResult),
    .fwdData       (rs2Fwd)
  );

  // Operand muxing and load-use detection against the instruction arriving from decode.
  always_comb begin
    operandA      = rs1Fwd;
    operandB      = aluSrcImm_q ? imm_q : rs2Fwd;
    storeData     = rs2Fwd;
    controlSignal = aluOp_q;
    rdAddrOut     = rd_q;
    regWriteOut   = ctrl_q.regWrite;
    memReadOut    = ctrl_q.memRead;
    memWriteOut   = ctrl_q.memWrite;
    outValid      = ctrl_q.valid;
    loadUseHazard = ctrl_q.valid && ctrl_q.memRead && (rd_q != '0) && inValid &&
                    ((rd_q == rs1Addr) || (rd_q == rs2Addr));
  end

endmodule

// File: tb/tb_execute_operand_stage.sv
// Directed bench for execute_operand_stage with a per-cycle reference model.
module tb_execute_operand_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall, flush, inValid;
  logic [31:0] rs1Data, rs2Data, immediate;
  logic [4:0]  rs1Addr, rs2Addr, rdAddr;
  logic [2:0]  aluControlIn;
  logic        aluSrcImm, regWriteIn, memReadIn, memWriteIn;
  logic        exMemRegWrite, memWbRegWrite;
  logic [4:0]  exMemRd, memWbRd;
  logic [31:0] exMemResult, memWbResult;
  logic [31:0] operandA, operandB, storeData;
  logic [2:0]  controlSignal;
  logic [4:0]  rdAddrOut;
  logic        regWriteOut, memReadOut, memWriteOut, outValid, loadUseHazard;

  int nAssert = 0;
  int nFail   = 0;

  execute_operand_stage #(
    .WIDTH   (32),
    .RADDR_W (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .inValid       (inValid),
    .rs1Data       (rs1Data),
    .rs2Data       (rs2Data),
    .immediate     (immediate),
    .rs1Addr       (rs1Addr),
    .rs2Addr       (rs2Addr),
    .rdAddr        (rdAddr),
    .aluControlIn  (aluControlIn),
    .aluSrcImm     (aluSrcImm),
    .regWriteIn    (regWriteIn),
    .memReadIn     (memReadIn),
    .memWriteIn    (memWriteIn),
    .exMemRegWrite (exMemRegWrite),
    .exMemRd       (exMemRd),
    .exMemResult   (exMemResult),
    .memWbRegWrite (memWbRegWrite),
    .memWbRd       (memWbRd),
    .memWbResult   (memWbResult),
    .operandA      (operandA),
    .operandB      (operandB),
    .controlSignal (controlSignal),
    .storeData     (storeData),
    .rdAddrOut     (rdAddrOut),
    .regWriteOut   (regWriteOut),
    .memReadOut    (memReadOut),
    .memWriteOut   (memWriteOut),
    .outValid      (outValid),
    .loadUseHazard (loadUseHazard)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the instruction held in execute; known=0 marks squashed data (don't-care).
  typedef struct {
    logic        valid, rw, mr, mw, srcImm, known;
    logic [31:0] rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic [2:0]  alu;
  } held_t;

  held_t m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= '{valid: 0, rw: 0, mr: 0, mw: 0, srcImm: 0, known: 1,
             rs1d: 0, rs2d: 0, imm: 0, rs1a: 0, rs2a: 0, rd: 0, alu: 0};
    end else if (flush) begin
      m <= '{valid: 0, rw: 0, mr: 0, mw: 0, srcImm: 0, known: 0,
             rs1d: 0, rs2d: 0, imm: 0, rs1a: 0, rs2a: 0, rd: 0, alu: 0};
    end else if (!stall) begin
      m <= '{valid: inValid, rw: inValid && regWriteIn, mr: inValid && memReadIn,
             mw: inValid && memWriteIn, srcImm: aluSrcImm, known: 1,
             rs1d: rs1Data, rs2d: rs2Data, imm: immediate, rs1a: rs1Addr, rs2a: rs2Addr,
             rd: rdAddr, alu: aluControlIn};
    end
  end

  // Value an operand must see: newest nonzero-destination writer wins, else held data.
  function automatic logic [31:0] bypass(input logic [4:0] a, input logic [31:0] held);
    if (a != 0 && exMemRegWrite && exMemRd == a) return exMemResult;
    if (a != 0 && memWbRegWrite && memWbRd == a) return memWbResult;
    return held;
  endfunction

  always @(negedge clk) begin
    check("outValid", {31'b0, outValid}, {31'b0, m.valid});
    check("regWriteOut", {31'b0, regWriteOut}, {31'b0, m.rw});
    check("memReadOut", {31'b0, memReadOut}, {31'b0, m.mr});
    check("memWriteOut", {31'b0, memWriteOut}, {31'b0, m.mw});
    check("loadUseHazard", {31'b0, loadUseHazard},
          {31'b0, m.valid && m.mr && m.rd != 0 && inValid &&
                  (m.rd == rs1Addr || m.rd == rs2Addr)});
    if (m.known) begin
      check("operandA", operandA, bypass(m.rs1a, m.rs1d));
      check("operandB", operandB, m.srcImm ? m.imm : bypass(m.rs2a, m.rs2d));
      check("storeData", storeData, bypass(m.rs2a, m.rs2d));
      check("controlSignal", {29'b0, controlSignal}, {29'b0, m.alu});
      check("rdAddrOut", {27'b0, rdAddrOut}, {27'b0, m.rd});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [4:0] a1, input logic [31:0] d1,
                           input logic [4:0] a2, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [4:0] rd,
                           input logic [2:0] alu, input logic si,
                           input logic rw, input logic mr, input logic mw);
    inValid = v; rs1Addr = a1; rs1Data = d1; rs2Addr = a2; rs2Data = d2;
    immediate = imm; rdAddr = rd; aluControlIn = alu; aluSrcImm = si;
    regWriteIn = rw; memReadIn = mr; memWriteIn = mw;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                         input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
    exMemRegWrite = ew; exMemRd = erd; exMemResult = eres;
    memWbRegWrite = ww; memWbRd = wrd; memWbResult = wres;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_opA"}, operandA, 32'h0);
    check({tag, "_opB"}, operandB, 32'h0);
    check({tag, "_store"}, storeData, 32'h0);
    check({tag, "_ctrl"}, {29'b0, controlSignal}, 32'h0);
    check({tag, "_valid"}, {31'b0, outValid}, 32'h0);
    check({tag, "_rw"}, {31'b0, regWriteOut}, 32'h0);
  endtask

  initial begin
    stall = 0; flush = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    repeat (2) probe();
    check_all_zero("reset");
    rst = 1'b0;

    // Dual forward: EX/MEM wins over MEM/WB, then fall back step by step
    set_instr(1, 5, 32'hAAAA, 3, 32'h1234, 32'h40, 9, 3'b001, 0, 1, 0, 0);
    tick();
    set_fwd(1, 5, 32'h11, 1, 5, 32'h22);
    probe();
    check("dual_fwd_opA", operandA, 32'h11);
    check("dual_fwd_opB", operandB, 32'h1234);
    check("dual_fwd_ctrl", {29'b0, controlSignal}, 32'h1);
    set_fwd(0, 5, 32'h11, 1, 5, 32'h22);
    #1 check("memwb_fwd_opA", operandA, 32'h22);
    set_fwd(0, 0, 0, 0, 0, 0);
    #1 check("no_fwd_opA", operandA, 32'hAAAA);

    // x0 guard
    set_instr(1, 1, 32'h10, 0, 0, 32'h77, 2, 3'b000, 0, 1, 0, 0);
    set_fwd(1, 0, 32'hFFFF, 0, 0, 0);
    tick();
    probe();
    check("x0_opB", operandB, 32'h0);
    check("x0_store", storeData, 32'h0);
    check("x0_opA", operandA, 32'h10);

    // Immediate operand while store data is forwarded
    set_instr(1, 2, 32'h20, 4, 32'h5, 32'h40, 6, 3'b000, 1, 0, 0, 1);
    set_fwd(1, 4, 32'h99, 0, 0, 0);
    tick();
    probe();
    check("imm_opB", operandB, 32'h40);
    check("imm_store", storeData, 32'h99);
    check("imm_memWrite", {31'b0, memWriteOut}, 32'h1);

    // Load-use against the incoming instruction
    set_fwd(0, 0, 0, 0, 0, 0);
    set_instr(1, 1, 1, 2, 2, 0, 7, 3'b000, 1, 1, 1, 0);
    tick();
    set_instr(1, 8, 0, 7, 0, 0, 3, 3'b000, 0, 1, 0, 0);
    probe();
    check("lu_hit", {31'b0, loadUseHazard}, 32'h1);
    inValid = 0;
    #1 check("lu_invalid", {31'b0, loadUseHazard}, 32'h0);
    set_instr(1, 1, 1, 2, 2, 0, 0, 3'b000, 1, 1, 1, 0);
    tick();
    set_instr(1, 0, 0, 0, 0, 0, 3, 3'b000, 0, 1, 0, 0);
    probe();
    check("lu_rd0", {31'b0, loadUseHazard}, 32'h0);

    // Stall holds for three cycles despite changing inputs
    set_instr(1, 10, 32'h100, 11, 32'h200, 0, 12, 3'b100, 0, 1, 0, 0);
    tick();
    stall = 1;
    set_instr(1, 20, 32'hDEAD, 21, 32'hBEEF, 32'h5, 13, 3'b010, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      probe();
      check("stall_opA", operandA, 32'h100);
      check("stall_opB", operandB, 32'h200);
      check("stall_ctrl", {29'b0, controlSignal}, 32'h4);
      check("stall_rd", {27'b0, rdAddrOut}, 32'd12);
      check("stall_rw", {31'b0, regWriteOut}, 32'h1);
    end

    // Flush beats stall
    flush = 1;
    tick();
    probe();
    check("flush_valid", {31'b0, outValid}, 32'h0);
    check("flush_rw", {31'b0, regWriteOut}, 32'h0);
    check("flush_mw", {31'b0, memWriteOut}, 32'h0);

    // Bubble capture forces controls low
    flush = 0; stall = 0;
    set_instr(0, 1, 1, 2, 2, 0, 4, 3'b011, 0, 1, 1, 1);
    tick();
    probe();
    check("bubble_rw", {31'b0, regWriteOut}, 32'h0);
    check("bubble_mr", {31'b0, memReadOut}, 32'h0);

    // Sweep opcodes with mixed forwarding sources; the per-cycle model checks these
    for (int i = 0; i < 7; i++) begin
      set_instr(1, 5'(i + 1), 32'(i * 3), 5'(i + 2), 32'(i * 5 + 1), 32'(i + 100),
                5'(i + 8), 3'(i), 1'(i % 3 == 0), 1, 1'(i % 2), 0);
      set_fwd(1'(i % 2), 5'(i + 1), 32'hE0 + 32'(i), 1, 5'(i + 2), 32'hB0 + 32'(i));
      tick();
    end

    // Asynchronous reset mid-operation, with stall and flush both high
    set_fwd(1, 8, 32'h1234_5678, 1, 9, 32'h8765_4321);
    set_instr(1, 8, 32'h3, 9, 32'h4, 0, 3, 3'b001, 0, 1, 0, 1);
    tick();
    stall = 1; flush = 1;
    #2 rst = 1;
    #1 check_all_zero("async_rst");
    probe();
    rst = 0; stall = 0; flush = 0;
    set_instr(1, 1, 32'h5, 2, 32'h6, 0, 3, 3'b110, 0, 1, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    tick();
    probe();
    check("post_rst_valid", {31'b0, outValid}, 32'h1);
    check("post_rst_rw", {31'b0, regWriteOut}, 32'h1);
    check("post_rst_rd", {27'b0, rdAddrOut}, 32'd3);
    check("post_rst_opA", operandA, 32'h5);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
